// File: rtl/her_credit_arbiter.sv
`default_nettype none
// ============================================================================
// her_credit_arbiter : round-robin HER merge with per-source in-flight credits
// Rev 1.0
// ============================================================================

package her_credit_arbiter_pkg;

   typedef struct packed {
      logic [15:0] msgid;
      logic        eom;
      logic [31:0] her_addr;
      logic [15:0] her_size;
   } her_descr_t;

   typedef struct packed {
      logic [15:0] msgid;
      logic [31:0] her_addr;
   } feedback_descr_t;

endpackage

module her_credit_arbiter
   import her_credit_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ      = 4,
   parameter  int unsigned MAX_INFLIGHT = 8,
   localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1),
   localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            pspin_active_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  her_descr_t [NUM_REQ-1:0]        req_descr_i,
   output logic                            her_valid_o,
   input  logic                            her_ready_i,
   output her_descr_t                      her_descr_o,
   input  logic                            feedback_valid_i,
   output logic                            feedback_ready_o,
   input  feedback_descr_t                 feedback_i,
   output logic [NUM_REQ-1:0][CNT_W-1:0]   inflight_o,
   output logic                            idle_o,
   output logic                            credit_err_o
);

   localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MAX_INFLIGHT);

   logic [ID_W-1:0]                rr_q;
   logic                           her_valid_q;
   her_descr_t                     her_descr_q;
   logic                           credit_err_q;
   logic [NUM_REQ-1:0][CNT_W-1:0]  inflight;

   logic [NUM_REQ-1:0]             eligible;
   logic [NUM_REQ-1:0]             grant;
   logic [ID_W-1:0]                grant_id;
   logic                           found;
   logic                           load_en;
   logic                           accept;
   logic [ID_W-1:0]                fb_id;
   logic                           err_set;
   logic                           unused_fb;

   assign fb_id     = feedback_i.msgid[ID_W-1:0];
   assign unused_fb = ^feedback_i;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid_i[i] && (inflight[i] < C_LIMIT) && pspin_active_i;
      end
   end

   // Search starts at rr_q; full sources are simply skipped so the pointer never stalls.
   always_comb begin
      grant    = '0;
      grant_id = rr_q;
      found    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && eligible[rr_q + ID_W'(k)]) begin
            found    = 1'b1;
            grant_id = rr_q + ID_W'(k);
         end
      end
      if (found) begin
         grant[grant_id] = 1'b1;
      end
   end

   assign load_en     = !her_valid_q || her_ready_i;
   assign accept      = load_en && found;
   assign req_ready_o = (load_en && rst_ni) ? grant : '0;
   assign err_set     = feedback_valid_i && (inflight[fb_id] == '0);

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      logic             inc;
      logic             dec;
      logic [CNT_W-1:0] cnt_q;

      assign inc = accept && (grant_id == ID_W'(i));
      assign dec = feedback_valid_i && (fb_id == ID_W'(i)) && (cnt_q != '0);

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
         end else if (inc && !dec) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (dec && !inc) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end

      assign inflight[i] = cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q         <= '0;
         her_valid_q  <= 1'b0;
         her_descr_q  <= '0;
         credit_err_q <= 1'b0;
      end else begin
         if (accept) begin
            her_valid_q <= 1'b1;
            her_descr_q <= req_descr_i[grant_id];
            rr_q        <= grant_id + ID_W'(1);
         end else if (her_ready_i) begin
            her_valid_q <= 1'b0;
         end
         if (err_set) begin
            credit_err_q <= 1'b1;
         end
      end
   end

   assign her_valid_o      = her_valid_q;
   assign her_descr_o      = her_descr_q;
   assign inflight_o       = inflight;
   assign idle_o           = !her_valid_q && (inflight == '0);
   assign credit_err_o     = credit_err_q;
   assign feedback_ready_o = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_her_credit_arbiter.sv
`default_nettype none
// ============================================================================
// tb_her_credit_arbiter : scoreboard bench for her_credit_arbiter
// Rev 1.0
// ============================================================================

module tb_her_credit_arbiter;
   import her_credit_arbiter_pkg::*;

   localparam int NUM_REQ      = 4;
   localparam int MAX_INFLIGHT = 8;
   localparam int CNT_W        = 4;
   localparam int ID_W         = 2;

   logic                          clk = 1'b0;
   logic                          rst_ni = 1'b0;
   logic                          pspin_active = 1'b1;
   logic [NUM_REQ-1:0]            req_valid = '0;
   logic [NUM_REQ-1:0]            req_ready;
   her_descr_t [NUM_REQ-1:0]      req_descr;
   logic                          her_valid;
   logic                          her_ready = 1'b0;
   her_descr_t                    her_descr;
   logic                          fb_valid = 1'b0;
   logic                          fb_ready;
   feedback_descr_t               fb = '0;
   logic [NUM_REQ-1:0][CNT_W-1:0] inflight;
   logic                          idle;
   logic                          credit_err;

   int          passed = 0;
   int          total  = 0;
   her_descr_t  exp_q[$];
   her_descr_t  mon_e;
   int          seq[NUM_REQ];

   // Reference model state
   int          m_rr;
   int          m_inf[NUM_REQ];
   bit          m_hv;
   bit          m_acc;
   int          m_gid;
   logic [NUM_REQ-1:0] m_ready;

   always #5 clk = ~clk;

   her_credit_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .pspin_active_i   (pspin_active),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_descr_i      (req_descr),
      .her_valid_o      (her_valid),
      .her_ready_i      (her_ready),
      .her_descr_o      (her_descr),
      .feedback_valid_i (fb_valid),
      .feedback_ready_o (fb_ready),
      .feedback_i       (fb),
      .inflight_o       (inflight),
      .idle_o           (idle),
      .credit_err_o     (credit_err)
   );

   function automatic her_descr_t make_descr(int src, int s);
      her_descr_t d;
      d.msgid    = 16'((s << ID_W) | src);
      d.eom      = s[0];
      d.her_addr = $urandom;
      d.her_size = 16'($urandom_range(64, 2048));
      return d;
   endfunction

   task automatic m_reset();
      m_rr  = 0;
      m_hv  = 1'b0;
      m_acc = 1'b0;
      m_gid = 0;
      for (int i = 0; i < NUM_REQ; i++) m_inf[i] = 0;
   endtask

   task automatic eval();
      bit load;
      int s;
      #1;
      load    = !m_hv || her_ready;
      m_acc   = 1'b0;
      m_gid   = 0;
      m_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         s = (m_rr + k) % NUM_REQ;
         if (!m_acc && req_valid[s] && m_inf[s] < MAX_INFLIGHT && pspin_active) begin
            m_acc = 1'b1;
            m_gid = s;
         end
      end
      if (!load) m_acc = 1'b0;
      if (m_acc) m_ready[m_gid] = 1'b1;
   endtask

   task automatic advance();
      int j;
      @(posedge clk);
      @(negedge clk);
      j = int'(fb.msgid[ID_W-1:0]);
      if (fb_valid && m_inf[j] > 0) m_inf[j]--;
      if (m_acc) begin
         exp_q.push_back(req_descr[m_gid]);
         m_hv = 1'b1;
         m_rr = (m_gid + 1) % NUM_REQ;
         m_inf[m_gid]++;
         seq[m_gid]++;
         req_descr[m_gid] = make_descr(m_gid, seq[m_gid]);
      end else if (her_ready) begin
         m_hv = 1'b0;
      end
   endtask

   task automatic quiesce();
      int j;
      req_valid = '0;
      her_ready = 1'b1;
      for (int n = 0; n < 64; n++) begin
         j = -1;
         for (int k = NUM_REQ - 1; k >= 0; k--) if (m_inf[k] > 0) j = k;
         if (j < 0 && !m_hv) break;
         fb_valid = (j >= 0);
         fb.msgid = 16'((j < 0) ? 0 : j);
         eval();
         advance();
      end
      fb_valid = 1'b0;
   endtask

   // Scoreboard: every HER the scheduler takes must be the next expected descriptor.
   always @(negedge clk) begin
      #3;
      if (rst_ni && her_valid && her_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL her_out: got msgid %h, required no HER", her_descr.msgid);
         end else begin
            mon_e = exp_q.pop_front();
            if (her_descr !== mon_e) $display("FAIL her_out: got %h, required %h", her_descr, mon_e);
            else passed++;
         end
      end
   end

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (her_valid !== 1'b0) $display("FAIL rst_her_valid: got %b, required 0", her_valid); else passed++;
      total++; if (her_descr !== '0) $display("FAIL rst_her_descr: got %h, required 0", her_descr); else passed++;
      total++; if (req_ready !== '0) $display("FAIL rst_req_ready: got %b, required 0", req_ready); else passed++;
      total++; if (inflight !== '0) $display("FAIL rst_inflight: got %h, required 0", inflight); else passed++;
      total++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b, required 1", idle); else passed++;
      total++; if (credit_err !== 1'b0) $display("FAIL rst_err: got %b, required 0", credit_err); else passed++;
      total++; if (fb_ready !== 1'b1) $display("FAIL rst_fb_ready: got %b, required 1", fb_ready); else passed++;
      rst_ni = 1'b1;
      m_reset();
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] exp;
      req_valid = 4'hF;
      her_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         fb_valid = (c > 0);
         fb.msgid = 16'((c > 0) ? (c - 1) % NUM_REQ : 0);
         eval();
         exp = 4'b0001 << (c % NUM_REQ);
         total++; if (req_ready !== exp) $display("FAIL rr_grant[%0d]: got %b, required %b", c, req_ready, exp); else passed++;
         if (c == 0) begin
            total++; if (her_valid !== 1'b0) $display("FAIL rr_pre_valid: got %b, required 0", her_valid); else passed++;
         end
         advance();
         if (c == 0) begin
            total++; if (her_valid !== 1'b1) $display("FAIL rr_first_valid: got %b, required 1", her_valid); else passed++;
         end
      end
      total++; if (inflight !== {4'd1, 4'd0, 4'd0, 4'd0}) $display("FAIL rr_inflight: got %h, required 1000", inflight); else passed++;
      quiesce();
      total++; if (idle !== 1'b1) $display("FAIL rr_idle: got %b, required 1", idle); else passed++;
   endtask

   task automatic test_credit_limit();
      logic [NUM_REQ-1:0] exp;
      req_valid = 4'b0100;
      her_ready = 1'b1;
      fb_valid  = 1'b0;
      for (int c = 0; c < 10; c++) begin
         eval();
         exp = (c < MAX_INFLIGHT) ? 4'b0100 : 4'b0000;
         total++; if (req_ready !== exp) $display("FAIL credit_ready[%0d]: got %b, required %b", c, req_ready, exp); else passed++;
         advance();
      end
      total++; if (inflight[2] !== 4'd8) $display("FAIL credit_full: got %0d, required 8", inflight[2]); else passed++;
      fb_valid = 1'b1;
      fb.msgid = 16'd2;
      eval();
      total++; if (req_ready !== 4'b0000) $display("FAIL credit_fb_cycle: got %b, required 0000", req_ready); else passed++;
      advance();
      fb_valid = 1'b0;
      total++; if (inflight[2] !== 4'd7) $display("FAIL credit_dec: got %0d, required 7", inflight[2]); else passed++;
      eval();
      total++; if (req_ready !== 4'b0100) $display("FAIL credit_regrant: got %b, required 0100", req_ready); else passed++;
      advance();
      total++; if (inflight[2] !== 4'd8) $display("FAIL credit_refull: got %0d, required 8", inflight[2]); else passed++;
      quiesce();
   endtask

   task automatic test_backpressure();
      req_valid = 4'b0011;
      her_ready = 1'b0;
      eval();
      total++; if (req_ready !== 4'b0001) $display("FAIL bp_first: got %b, required 0001", req_ready); else passed++;
      advance();
      for (int c = 0; c < 5; c++) begin
         eval();
         total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b, required 0000", c, req_ready); else passed++;
         total++;
         if (exp_q.size() == 0 || her_valid !== 1'b1 || her_descr !== exp_q[0])
            $display("FAIL bp_stable[%0d]: got valid %b descr %h, required held HER", c, her_valid, her_descr);
         else passed++;
         advance();
      end
      her_ready = 1'b1;
      eval();
      total++; if (req_ready !== 4'b0010) $display("FAIL bp_release: got %b, required 0010", req_ready); else passed++;
      advance();
      total++; if (inflight[1:0] !== {4'd1, 4'd1}) $display("FAIL bp_inflight: got %h, required 11", inflight[1:0]); else passed++;
      quiesce();
   endtask

   task automatic test_simultaneous();
      req_valid = 4'b1000;
      her_ready = 1'b1;
      repeat (4) begin
         eval();
         advance();
      end
      total++; if (inflight[3] !== 4'd4) $display("FAIL sim_pre: got %0d, required 4", inflight[3]); else passed++;
      fb_valid = 1'b1;
      fb.msgid = 16'd3;
      eval();
      total++; if (req_ready !== 4'b1000) $display("FAIL sim_grant: got %b, required 1000", req_ready); else passed++;
      advance();
      fb_valid = 1'b0;
      total++; if (inflight[3] !== 4'd4) $display("FAIL sim_net0: got %0d, required 4", inflight[3]); else passed++;
      quiesce();
   endtask

   task automatic test_underflow();
      total++; if (credit_err !== 1'b0) $display("FAIL uf_pre: got %b, required 0", credit_err); else passed++;
      req_valid = '0;
      fb_valid  = 1'b1;
      fb.msgid  = 16'd1;
      eval();
      advance();
      fb_valid = 1'b0;
      total++; if (inflight[1] !== 4'd0) $display("FAIL uf_count: got %0d, required 0", inflight[1]); else passed++;
      total++; if (credit_err !== 1'b1) $display("FAIL uf_err: got %b, required 1", credit_err); else passed++;
      repeat (3) begin
         eval();
         advance();
      end
      total++; if (credit_err !== 1'b1) $display("FAIL uf_sticky: got %b, required 1", credit_err); else passed++;
   endtask

   task automatic test_gating();
      req_valid    = 4'hF;
      her_ready    = 1'b0;
      pspin_active = 1'b1;
      eval();
      advance();
      pspin_active = 1'b0;
      repeat (2) begin
         eval();
         total++; if (req_ready !== 4'b0000) $display("FAIL gate_stall_ready: got %b, required 0000", req_ready); else passed++;
         advance();
         total++; if (her_valid !== 1'b1) $display("FAIL gate_held: got %b, required 1", her_valid); else passed++;
      end
      her_ready = 1'b1;
      eval();
      total++; if (req_ready !== 4'b0000) $display("FAIL gate_drain_ready: got %b, required 0000", req_ready); else passed++;
      advance();
      total++; if (her_valid !== 1'b0) $display("FAIL gate_drained: got %b, required 0", her_valid); else passed++;
      fb_valid = 1'b1;
      fb.msgid = 16'd0;
      eval();
      advance();
      fb_valid = 1'b0;
      total++; if (inflight !== '0) $display("FAIL gate_fb: got %h, required 0", inflight); else passed++;
      total++; if (idle !== 1'b1) $display("FAIL gate_idle: got %b, required 1", idle); else passed++;
      pspin_active = 1'b1;
      req_valid    = '0;
   endtask

   task automatic test_reset_mid();
      req_valid = 4'hF;
      her_ready = 1'b0;
      eval();
      advance();
      her_ready = 1'b1;
      eval();
      advance();
      #2;
      rst_ni = 1'b0;
      #1;
      total++; if (her_valid !== 1'b0) $display("FAIL mid_valid: got %b, required 0", her_valid); else passed++;
      total++; if (inflight !== '0) $display("FAIL mid_inflight: got %h, required 0", inflight); else passed++;
      total++; if (idle !== 1'b1) $display("FAIL mid_idle: got %b, required 1", idle); else passed++;
      total++; if (credit_err !== 1'b0) $display("FAIL mid_err: got %b, required 0", credit_err); else passed++;
      total++; if (req_ready !== '0) $display("FAIL mid_ready: got %b, required 0", req_ready); else passed++;
      @(negedge clk);
      rst_ni = 1'b1;
      exp_q.delete();
      m_reset();
      eval();
      total++; if (req_ready !== 4'b0001) $display("FAIL mid_restart: got %b, required 0001", req_ready); else passed++;
      advance();
      quiesce();
   endtask

   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin
         seq[i]       = 0;
         req_descr[i] = make_descr(i, 0);
      end
      m_reset();
      test_reset();
      test_round_robin();
      test_credit_limit();
      test_backpressure();
      test_simultaneous();
      test_underflow();
      test_gating();
      test_reset_mid();
      repeat (2) @(negedge clk);
      total++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d queued, required 0", exp_q.size()); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
